vga_sync: RTL

VGA 640x480@60 Hz raster timing generator; sits directly upstream of the colour-generation stage. Produces the pixel coordinates and active-video qualifier that the colour stage consumes, plus horizontal and vertical sync pulses. The sync outputs are delayed one cycle so they align with the colour stage's registered RGB outputs at the connector. The pixel rate is derived from the system clock by an internal clock-enable divider.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_sync_if.sv | 31 +++
 rtl/vga_pix_div.sv | 27 ++
 rtl/vga_sync.sv | 98 +++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster constants, coordinate type and phase decode used by vga_sync
// and by the downstream colour stage.
package vga_pkg;

   localparam int CLK_DIV_DEF  = 4;
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   // Same phase ordering applies to lines within a frame and pixels within a line.
   typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} h_phase_t;

   function automatic h_phase_t phase_of(input coord_t pos, input int act,
                                         input int fp, input int sync);
      int p;
      p = int'(pos);
      if (p < act)
         return ACTIVE;
      else if (p < act + fp)
         return FP;
      else if (p < act + fp + sync)
         return SYNC;
      return BP;
   endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Raster timing bundle from vga_sync to the colour stage.
// o_frame_cnt exists only when VGA_SYNC_FRAME_CNT_EN is defined.
interface vga_sync_if;
   import vga_pkg::*;

   logic   o_pix_en;
   logic   o_pix_valid;
   coord_t o_col;
   coord_t o_row;
   logic   o_hsync;
   logic   o_vsync;
   logic   o_frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [7:0] o_frame_cnt;
`endif

   modport master (
      output o_pix_en, o_pix_valid, o_col, o_row, o_hsync, o_vsync, o_frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
      , output o_frame_cnt
`endif
   );

   modport slave (
      input o_pix_en, o_pix_valid, o_col, o_row, o_hsync, o_vsync, o_frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
      , input o_frame_cnt
`endif
   );

endinterface

// File: rtl/vga_pix_div.sv
// Pixel clock-enable divider: one-clk tick every CLK_DIV system clocks.
// With CLK_DIV = 1 the counter sits at its terminal value, so the tick is constant.
module vga_pix_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic o_pix_en
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div;

   always_ff @(posedge clk) begin
      if (rst)
         div <= '0;
      else if (div == DIV_LAST)
         div <= '0;
      else
         div <= div + 1'b1;
   end

   assign o_pix_en = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel counters, active-video qualifier and syncs
// delayed one clk to match the registered RGB path. Frame counter under VGA_SYNC_FRAME_CNT_EN.
module vga_sync
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = CLK_DIV_DEF,
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic       clk,
   input  logic       rst,
   vga_sync_if.master vo
);

   localparam int     H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int     V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);

   logic     pix_en_p0;
   coord_t   col_p0;
   coord_t   row_p0;
   h_phase_t h_ph_p0;
   h_phase_t v_ph_p0;
   logic     vld_p0;
   logic     wrap_p0;

   logic     hsync_p1;
   logic     vsync_p1;
   logic     frame_start_p1;

   vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
      .clk      (clk),
      .rst      (rst),
      .o_pix_en (pix_en_p0)
   );

   // Stage p0: raster counters, advanced only on the pixel tick
   always_ff @(posedge clk) begin
      if (rst) begin
         col_p0 <= '0;
         row_p0 <= '0;
      end else if (pix_en_p0) begin
         if (col_p0 == H_LAST) begin
            col_p0 <= '0;
            row_p0 <= (row_p0 == V_LAST) ? '0 : row_p0 + 1'b1;
         end else begin
            col_p0 <= col_p0 + 1'b1;
         end
      end
   end

   assign h_ph_p0 = phase_of(col_p0, H_ACTIVE, H_FP, H_SYNC);
   assign v_ph_p0 = phase_of(row_p0, V_ACTIVE, V_FP, V_SYNC);
   assign vld_p0  = !rst && (h_ph_p0 == ACTIVE) && (v_ph_p0 == ACTIVE);
   assign wrap_p0 = pix_en_p0 && (col_p0 == H_LAST) && (row_p0 == V_LAST);

   // Stage p1: syncs and frame marker, one clk behind the counters
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_p1       <= 1'b1;
         vsync_p1       <= 1'b1;
         frame_start_p1 <= 1'b0;
      end else begin
         hsync_p1       <= (h_ph_p0 != SYNC);
         vsync_p1       <= (v_ph_p0 != SYNC);
         frame_start_p1 <= wrap_p0;
      end
   end

`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [7:0] frame_cnt_p1;

   always_ff @(posedge clk) begin
      if (rst)
         frame_cnt_p1 <= '0;
      else if (wrap_p0)
         frame_cnt_p1 <= frame_cnt_p1 + 8'd1;
   end

   assign vo.o_frame_cnt = frame_cnt_p1;
`endif

   assign vo.o_pix_en      = pix_en_p0;
   assign vo.o_pix_valid   = vld_p0;
   assign vo.o_col         = col_p0;
   assign vo.o_row         = row_p0;
   assign vo.o_hsync       = hsync_p1;
   assign vo.o_vsync       = vsync_p1;
   assign vo.o_frame_start = frame_start_p1;

endmodule
